// File: rtl/myvision_kbd_pkg.sv
// Shared constants for the MyVision keypad front-end: PS/2 scancodes,
// button indices and joystick bit positions.
package myvision_kbd_pkg;

   localparam int unsigned NUM_BTN   = 19;
   localparam int unsigned BTN_IDX_W = 5;

   localparam int unsigned BTN_K1    = 0;
   localparam int unsigned BTN_K2    = 1;
   localparam int unsigned BTN_K3    = 2;
   localparam int unsigned BTN_K4    = 3;
   localparam int unsigned BTN_K5    = 4;
   localparam int unsigned BTN_K6    = 5;
   localparam int unsigned BTN_K7    = 6;
   localparam int unsigned BTN_K8    = 7;
   localparam int unsigned BTN_K9    = 8;
   localparam int unsigned BTN_K10   = 9;
   localparam int unsigned BTN_K11   = 10;
   localparam int unsigned BTN_K12   = 11;
   localparam int unsigned BTN_K13   = 12;
   localparam int unsigned BTN_K14   = 13;
   localparam int unsigned BTN_UP    = 14;
   localparam int unsigned BTN_DOWN  = 15;
   localparam int unsigned BTN_LEFT  = 16;
   localparam int unsigned BTN_RIGHT = 17;
   localparam int unsigned BTN_FIRE  = 18;

   localparam int unsigned JOY_RIGHT = 0;
   localparam int unsigned JOY_LEFT  = 1;
   localparam int unsigned JOY_DOWN  = 2;
   localparam int unsigned JOY_UP    = 3;
   localparam int unsigned JOY_FIRE  = 4;
   localparam int unsigned JOY_AUTO  = 5;
   localparam int unsigned JOY_W     = 6;

   localparam logic [7:0] SC_1      = 8'h16;
   localparam logic [7:0] SC_A      = 8'h1C;
   localparam logic [7:0] SC_2      = 8'h1E;
   localparam logic [7:0] SC_B      = 8'h32;
   localparam logic [7:0] SC_3      = 8'h26;
   localparam logic [7:0] SC_C      = 8'h21;
   localparam logic [7:0] SC_4      = 8'h25;
   localparam logic [7:0] SC_D      = 8'h23;
   localparam logic [7:0] SC_5      = 8'h2E;
   localparam logic [7:0] SC_E      = 8'h24;
   localparam logic [7:0] SC_6      = 8'h36;
   localparam logic [7:0] SC_F      = 8'h2B;
   localparam logic [7:0] SC_7      = 8'h3D;
   localparam logic [7:0] SC_G      = 8'h34;
   localparam logic [7:0] SC_8      = 8'h3E;
   localparam logic [7:0] SC_H      = 8'h33;
   localparam logic [7:0] SC_9      = 8'h46;
   localparam logic [7:0] SC_I      = 8'h43;
   localparam logic [7:0] SC_0      = 8'h45;
   localparam logic [7:0] SC_J      = 8'h3B;
   localparam logic [7:0] SC_MINUS  = 8'h4E;
   localparam logic [7:0] SC_K      = 8'h42;
   localparam logic [7:0] SC_EQUAL  = 8'h55;
   localparam logic [7:0] SC_L      = 8'h4B;
   localparam logic [7:0] SC_BKSP   = 8'h66;
   localparam logic [7:0] SC_M      = 8'h3A;
   localparam logic [7:0] SC_BSLASH = 8'h5D;
   localparam logic [7:0] SC_N      = 8'h31;
   localparam logic [7:0] SC_UP     = 8'h75;
   localparam logic [7:0] SC_DOWN   = 8'h72;
   localparam logic [7:0] SC_LEFT   = 8'h6B;
   localparam logic [7:0] SC_RIGHT  = 8'h74;
   localparam logic [7:0] SC_SPACE  = 8'h29;

   typedef struct packed {
      logic                 valid;
      logic [BTN_IDX_W-1:0] idx;
   } btn_hit_t;

   // Map a scancode to its button; two codes alias onto each keypad key.
   function automatic btn_hit_t btn_lookup(input logic [7:0] code);
      btn_hit_t hit;
      hit.valid = 1'b1;
      hit.idx   = '0;
      case (code)
         SC_1, SC_A:          hit.idx = BTN_IDX_W'(BTN_K1);
         SC_2, SC_B:          hit.idx = BTN_IDX_W'(BTN_K2);
         SC_3, SC_C:          hit.idx = BTN_IDX_W'(BTN_K3);
         SC_4, SC_D:          hit.idx = BTN_IDX_W'(BTN_K4);
         SC_5, SC_E:          hit.idx = BTN_IDX_W'(BTN_K5);
         SC_6, SC_F:          hit.idx = BTN_IDX_W'(BTN_K6);
         SC_7, SC_G:          hit.idx = BTN_IDX_W'(BTN_K7);
         SC_8, SC_H:          hit.idx = BTN_IDX_W'(BTN_K8);
         SC_9, SC_I:          hit.idx = BTN_IDX_W'(BTN_K9);
         SC_0, SC_J:          hit.idx = BTN_IDX_W'(BTN_K10);
         SC_MINUS, SC_K:      hit.idx = BTN_IDX_W'(BTN_K11);
         SC_EQUAL, SC_L:      hit.idx = BTN_IDX_W'(BTN_K12);
         SC_BKSP, SC_M:       hit.idx = BTN_IDX_W'(BTN_K13);
         SC_BSLASH, SC_N:     hit.idx = BTN_IDX_W'(BTN_K14);
         SC_UP:               hit.idx = BTN_IDX_W'(BTN_UP);
         SC_DOWN:             hit.idx = BTN_IDX_W'(BTN_DOWN);
         SC_LEFT:             hit.idx = BTN_IDX_W'(BTN_LEFT);
         SC_RIGHT:            hit.idx = BTN_IDX_W'(BTN_RIGHT);
         SC_SPACE:            hit.idx = BTN_IDX_W'(BTN_FIRE);
         default:             hit.valid = 1'b0;
      endcase
      return hit;
   endfunction

endpackage

// File: rtl/myvision_autofire.sv
// Autofire phase generator: toggles phase_o every DIV cycles while enabled,
// clears immediately when disabled.
module myvision_autofire #(
   parameter logic [23:0] DIV = 24'd298_000
) (
   input  logic clk_sys,
   input  logic reset_n,
   input  logic enable,
   output logic phase_o
);

   localparam int unsigned CNT_W = 24;

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q   <= '0;
         phase_o <= 1'b0;
      end else if (!enable || DIV == '0) begin
         cnt_q   <= '0;
         phase_o <= 1'b0;
      end else if (cnt_q == DIV - CNT_W'(1)) begin
         cnt_q   <= '0;
         phase_o <= ~phase_o;
      end else begin
         cnt_q   <= cnt_q + CNT_W'(1);
      end
   end

endmodule

// File: rtl/myvision_keypad.sv
// MyVision keypad front-end: PS/2 and joystick input folded into the 4-row
// active-low matrix that the PSG scans through port B and reads on port A.
module myvision_keypad
   import myvision_kbd_pkg::*;
#(
   parameter logic [23:0] AUTOFIRE_DIV = 24'd298_000,
   parameter bit          USE_JOY1     = 1'b1
) (
   input  logic                clk_sys,
   input  logic                reset_n,
   input  logic [10:0]         ps2_key,
   input  logic [31:0]         joy0,
   input  logic [31:0]         joy1,
   input  logic [7:0]          key_column,
   output logic [7:0]          keydata,
   output logic [NUM_BTN-1:0]  key_state
);

   logic              armed_q;
   logic              old_toggle_q;
   logic              ps2_event_c;
   btn_hit_t          hit_c;
   logic [JOY_W-1:0]  pad_c;
   logic              af_phase;
   logic [NUM_BTN-1:0] eff_c;
   logic [7:0]        row0_c, row1_c, row2_c, row3_c, keydata_d_c;
   logic              unused_bits;

   assign unused_bits = ^{joy0[31:JOY_W], joy1[31:JOY_W], key_column[3:0], ps2_key[8]};

   assign hit_c       = btn_lookup(ps2_key[7:0]);
   assign ps2_event_c = armed_q && (old_toggle_q != ps2_key[10]);
   assign pad_c       = joy0[JOY_W-1:0] | (USE_JOY1 ? joy1[JOY_W-1:0] : JOY_W'(0));

   // First cycle after reset only samples the toggle so a stale level is not seen as an event.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         armed_q      <= 1'b0;
         old_toggle_q <= 1'b0;
         key_state    <= '1;
      end else begin
         armed_q      <= 1'b1;
         old_toggle_q <= ps2_key[10];
         if (ps2_event_c && hit_c.valid)
            key_state[hit_c.idx] <= ~ps2_key[9];
      end
   end

   myvision_autofire #(
      .DIV     (AUTOFIRE_DIV)
   ) u_autofire (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .enable  (pad_c[JOY_AUTO]),
      .phase_o (af_phase)
   );

   // Keyboard bits gated by joystick directions/fire (active high pad, active low buttons).
   always_comb begin
      eff_c            = key_state;
      eff_c[BTN_UP]    = key_state[BTN_UP]    & ~pad_c[JOY_UP];
      eff_c[BTN_DOWN]  = key_state[BTN_DOWN]  & ~pad_c[JOY_DOWN];
      eff_c[BTN_LEFT]  = key_state[BTN_LEFT]  & ~pad_c[JOY_LEFT];
      eff_c[BTN_RIGHT] = key_state[BTN_RIGHT] & ~pad_c[JOY_RIGHT];
      eff_c[BTN_FIRE]  = key_state[BTN_FIRE]  & ~pad_c[JOY_FIRE]
                         & ~(pad_c[JOY_AUTO] & af_phase);
   end

   always_comb begin
      row0_c = {eff_c[BTN_K1], eff_c[BTN_K5], eff_c[BTN_K9],  eff_c[BTN_DOWN],  eff_c[BTN_K13], 3'b111};
      row1_c = {eff_c[BTN_K4], eff_c[BTN_K8], eff_c[BTN_K12], 1'b1,             eff_c[BTN_UP],  3'b111};
      row2_c = {eff_c[BTN_K2], eff_c[BTN_K6], eff_c[BTN_K10], eff_c[BTN_RIGHT], eff_c[BTN_K14], 3'b111};
      row3_c = {eff_c[BTN_K3], eff_c[BTN_K7], eff_c[BTN_K11], eff_c[BTN_FIRE],  eff_c[BTN_LEFT], 3'b111};
   end

   // Selected rows AND together, so multiple low columns ghost as on the real matrix.
   assign keydata_d_c = (key_column[7] ? 8'hFF : row0_c)
                      & (key_column[6] ? 8'hFF : row1_c)
                      & (key_column[5] ? 8'hFF : row2_c)
                      & (key_column[4] ? 8'hFF : row3_c);

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n)
         keydata <= 8'hFF;
      else
         keydata <= keydata_d_c;
   end

endmodule

// File: tb/tb_myvision_keypad.sv
// Directed self-checking bench for myvision_keypad with a short autofire period.
module tb_myvision_keypad;

   logic        clk_sys;
   logic        reset_n;
   logic [10:0] ps2_key;
   logic [31:0] joy0;
   logic [31:0] joy1;
   logic [7:0]  key_column;
   logic [7:0]  keydata;
   logic [18:0] key_state;

   int unsigned n_checks;
   int unsigned n_fail;
   logic        toggle;

   myvision_keypad #(
      .AUTOFIRE_DIV (24'd4),
      .USE_JOY1     (1'b1)
   ) dut (
      .clk_sys    (clk_sys),
      .reset_n    (reset_n),
      .ps2_key    (ps2_key),
      .joy0       (joy0),
      .joy1       (joy1),
      .key_column (key_column),
      .keydata    (keydata),
      .key_state  (key_state)
   );

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk_sys);
      #1;
   endtask

   task automatic send_key(input logic pressed, input logic [7:0] code);
      toggle  = ~toggle;
      ps2_key = {toggle, pressed, 1'b0, code};
      step(2);
   endtask

   initial begin
      n_checks   = 0;
      n_fail     = 0;
      toggle     = 1'b1;
      reset_n    = 1'b0;
      ps2_key    = {1'b1, 1'b1, 1'b0, 8'h16};
      joy0       = '0;
      joy1       = '0;
      key_column = 8'h7F;
      step(3);
      check_eq("reset_keydata", 32'(keydata), 32'h FF);
      check_eq("reset_state", 32'(key_state), 32'h7FFFF);
      reset_n = 1'b1;
      step(3);
      check_eq("no_phantom_kd", 32'(keydata), 32'hFF);
      check_eq("no_phantom_st", 32'(key_state), 32'h7FFFF);

      // k1 press: decode after one edge, keydata after two
      toggle  = ~toggle;
      ps2_key = {toggle, 1'b1, 1'b0, 8'h16};
      step(1);
      check_eq("k1_lat1", 32'(keydata), 32'hFF);
      step(1);
      check_eq("k1_press", 32'(keydata), 32'h7F);
      check_eq("k1_state", 32'(key_state), 32'h7FFFE);
      send_key(1'b0, 8'h16);
      check_eq("k1_release", 32'(keydata), 32'hFF);

      // aliasing: 1 and A share k1, last event wins
      send_key(1'b1, 8'h16);
      send_key(1'b1, 8'h1C);
      check_eq("alias_held", 32'(keydata), 32'h7F);
      send_key(1'b0, 8'h16);
      check_eq("alias_rel", 32'(keydata), 32'hFF);
      send_key(1'b0, 8'h1C);
      send_key(1'b1, 8'h00);
      check_eq("unlisted", 32'(key_state), 32'h7FFFF);

      // joystick directions
      joy0[3] = 1'b1; key_column = 8'hBF;
      step(1);
      check_eq("joy_up_row1", 32'(keydata), 32'hF7);
      key_column = 8'h7F;
      step(1);
      check_eq("joy_up_row0", 32'(keydata), 32'hFF);
      joy0 = '0; joy1[2] = 1'b1;
      step(1);
      check_eq("joy1_down", 32'(keydata), 32'hEF);
      joy1 = '0;
      step(1);
      check_eq("joy1_clear", 32'(keydata), 32'hFF);

      // keyboard right arrow on row2
      key_column = 8'hDF;
      send_key(1'b1, 8'h74);
      check_eq("kbd_right", 32'(keydata), 32'hEF);
      send_key(1'b0, 8'h74);
      check_eq("kbd_right_rel", 32'(keydata), 32'hFF);

      // no column selected
      send_key(1'b1, 8'h16);
      key_column = 8'hFF;
      step(1);
      check_eq("no_col", 32'(keydata), 32'hFF);
      send_key(1'b0, 8'h16);

      // autofire with period 4: FF x4 then EF x4 ...
      key_column = 8'hEF;
      joy0[5] = 1'b1;
      for (int k = 1; k <= 14; k++) begin
         step(1);
         check_eq($sformatf("af_%0d", k), 32'(keydata), ((((k - 1) / 4) % 2) != 0) ? 32'hEF : 32'hFF);
      end
      joy0[5] = 1'b0;
      step(1);
      check_eq("af_drop", 32'(keydata), 32'hFF);
      step(1);
      joy0[5] = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         step(1);
         check_eq($sformatf("af_restart_%0d", k), 32'(keydata), (k == 5) ? 32'hEF : 32'hFF);
      end
      joy0[5] = 1'b0;
      joy0[4] = 1'b1;
      step(1);
      check_eq("joy_fire", 32'(keydata), 32'hEF);
      joy0 = '0;

      // ghosting: k1 (row0) and k4 (row1) with both rows selected
      key_column = 8'h3F;
      send_key(1'b1, 8'h16);
      send_key(1'b1, 8'h25);
      check_eq("ghost", 32'(keydata), 32'h7F);
      reset_n = 1'b0;
      #1;
      check_eq("rst_mid_kd", 32'(keydata), 32'hFF);
      check_eq("rst_mid_st", 32'(key_state), 32'h7FFFF);
      step(1);
      reset_n = 1'b1;
      step(3);
      check_eq("held_no_make", 32'(keydata), 32'hFF);
      send_key(1'b1, 8'h25);
      check_eq("new_make", 32'(keydata), 32'h7F);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/myvision_keypad.md
Name: myvision_keypad

Overview:
- Keyboard/joystick matrix front-end for the MyVision core.
- Decodes MiSTer-style PS/2 key events and joystick words into the 4-row active-low key matrix.
- Drives YM2149 port A input (I_IOA) from the column select that the PSG drives on port B (O_IOB[7:4]).
- Sits directly upstream of the PSG I/O ports and replaces the inline keyboard decode in the top level.

Parameters:
- AUTOFIRE_DIV, 24'd298_000, clk_sys cycles per autofire half-period; 0 disables autofire.
- USE_JOY1, 1, 1 = joy1 OR'd with joy0 into the same buttons; 0 = joy1 ignored.

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- ps2_key  in  11  [10] toggle-on-event, [9] pressed, [8] extended, [7:0] scancode.
- joy0  in  32  active-high: [0] right, [1] left, [2] down, [3] up, [4] fire, [5] autofire.
- joy1  in  32  same layout as joy0.
- key_column  in  8  PSG port B; bits [7:4] select rows 0..3, active low; bits [3:0] unused.
- keydata  out  8  PSG port A, active low, registered.
- key_state  out  19  debug: current keyboard button bits, active low, order k1..k14, up, down, left, right, fire.

Behaviour:
- Reset (async assert): all 19 button bits = 1 (released); keydata = 8'hFF; armed = 0; autofire phase = 0; autofire counter = 0.
- Event detect:
  - Register old_toggle. On the first clk_sys after reset release, load old_toggle <= ps2_key[10] and set armed, with no decode. This prevents a phantom event.
  - While armed, an event is old_toggle != ps2_key[10]. Decode happens in that same cycle and the button bit is updated at the next edge.
  - Button bit <= ~ps2_key[9].
- Scancode map (code[7:0]; code[8] ignored):
  - k1: 16, 1C
  - k2: 1E, 32
  - k3: 26, 21
  - k4: 25, 23
  - k5: 2E, 24
  - k6: 36, 2B
  - k7: 3D, 34
  - k8: 3E, 33
  - k9: 46, 43
  - k10: 45, 3B
  - k11: 4E, 42
  - k12: 55, 4B
  - k13: 66, 3A
  - k14: 5D, 31
  - up: 75; down: 72; left: 6B; right: 74; fire: 29.
  - Unlisted codes are ignored.
- Aliased keys share one bit: the last event wins. For example, press 1, press A, release 1 leaves k1 released.
- Joystick merge (per direction/fire): pad = joy0 | (USE_JOY1 ? joy1 : 0). Effective bit = kbd_bit & ~pad_bit.
- Fire additionally: & ~(pad[5] & af_phase).
- Autofire:
  - A counter counts clk_sys cycles. At AUTOFIRE_DIV-1 it wraps to 0 and toggles af_phase.
  - The counter runs only while pad[5] = 1. On pad[5] 1->0 the counter and af_phase clear.
  - AUTOFIRE_DIV = 0 forces af_phase = 0.
- Matrix rows (bit7..bit0, active low):
  - row0 = {k1, k5, k9, down, k13, 1, 1, 1}
  - row1 = {k4, k8, k12, 1, up, 1, 1, 1}
  - row2 = {k2, k6, k10, right, k14, 1, 1, 1}
  - row3 = {k3, k7, k11, fire, left, 1, 1, 1}
- keydata: registered each clk_sys as FF & (col[7] ? FF : row0) & (col[6] ? FF : row1) & (col[5] ? FF : row2) & (col[4] ? FF : row3).
- Latency:
  - 1 cycle from a key_column change to keydata.
  - 2 cycles from a ps2 toggle edge to keydata.
  - 1 cycle from a joy change to keydata.
- Multiple columns low: the selected rows are AND'd (ghosting allowed, as on hardware).
- No columns low: keydata = FF.
- Reset mid-press: every button reads released; a held key needs a new make event.

Decomposition:
- Package myvision_kbd_pkg holds:
  - scancode localparams (SC_1, SC_A, SC_UP, ...);
  - button index constants BTN_K1..BTN_FIRE (0..18);
  - JOY_RIGHT..JOY_AUTO bit indices.
- Sub-module myvision_autofire (clk_sys, reset_n, enable, phase_o) wraps the AUTOFIRE_DIV counter and phase toggle.

Test Plan:
- Reset release with ps2_key[10] = 1 and col = 8'h7F -> keydata stays FF (no phantom event); key_state = all 1s.
- Toggle with code 0x16 pressed, col = 8'h7F -> 2 cycles later keydata = 8'h7F. Release event -> FF.
- Press 0x16 then 0x1C, then release 0x16 -> k1 released; col 7F gives keydata FF despite A held.
- joy0[3] = 1, col = 8'hBF -> keydata = 8'hF7 one cycle later. Same with col = 8'h7F -> FF.
- AUTOFIRE_DIV = 4, joy0[5] = 1, col = 8'hEF -> keydata alternates FF / EF every 4 cycles. Drop joy0[5] -> FF next cycle.
- Press k1 and k4, col = 8'h3F -> keydata = 8'h7F. Assert reset_n low mid-hold -> keydata FF immediately.
